// File: rtl/pot_display_pkg.sv
// Shared constants for the pot position display: segment patterns,
// converter FSM encoding and digit slot indices.
package pot_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_e;

  // Active-high gfedcba patterns.
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [1:0] DIG_UNITS    = 2'd0;
  localparam logic [1:0] DIG_TENS     = 2'd1;
  localparam logic [1:0] DIG_HUNDREDS = 2'd2;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    logic [6:0] seg;
    seg = SEG_OFF;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd8.sv
// Iterative 8-bit binary to 3-digit BCD converter (shift-add-3), one bit per clock.
// Load pulses for one cycle while the finished result is valid on the outputs.
module bin2bcd8
  import pot_display_pkg::*;
(
  input  logic       nReset,
  input  logic       Clk,
  input  logic       Start,
  input  logic [7:0] Value,
  output logic       Busy,
  output logic       Load,
  output logic [1:0] Hundreds,
  output logic [3:0] Tens,
  output logic [3:0] Units
);

  conv_state_e state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [9:0]  acc_q, acc_d;
  logic [2:0]  iter_q, iter_d;
  logic [9:0]  adj;

  // Hundreds never exceeds 2 for an 8-bit input, so only tens and units need correction.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_adj
      assign adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? acc_q[gi*4 +: 4] + 4'd3
                                                          : acc_q[gi*4 +: 4];
    end
  endgenerate
  assign adj[9:8] = acc_q[9:8];

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      shift_q <= 8'd0;
      acc_q   <= 10'd0;
      iter_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      iter_q  <= iter_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    iter_d  = iter_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          shift_d = Value;
          acc_d   = 10'd0;
          iter_d  = 3'd0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        acc_d   = {adj[8:0], shift_q[7]};
        shift_d = {shift_q[6:0], 1'b0};
        iter_d  = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = ST_LOAD;
      end
      ST_LOAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  assign Busy     = (state_q != ST_IDLE);
  assign Load     = (state_q == ST_LOAD);
  assign Hundreds = acc_q[9:8];
  assign Tens     = acc_q[7:4];
  assign Units    = acc_q[3:0];

endmodule

// File: rtl/pot_display.sv
// Three-digit multiplexed 7-segment readout of the digital-pot position,
// with leading-zero blanking and a dead time at the start of each digit slot.
module pot_display
  import pot_display_pkg::*;
#(
  parameter int ScanDiv      = 390,
  parameter int DeadTime     = 2,
  parameter bit SegActiveLow = 1'b0,
  parameter bit DigActiveLow = 1'b0
) (
  input  logic       nReset,
  input  logic       Clk,
  input  logic [7:0] Value,
  output logic [7:0] Segments,
  output logic [2:0] Digit,
  output logic       Busy
);

  logic [7:0] last_q, last_d;
  logic [9:0] disp_q, disp_d;
  logic [9:0] slot_q, slot_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] seg_q, seg_d;
  logic [2:0] dig_q, dig_d;

  logic       conv_busy, conv_load, conv_start;
  logic [1:0] conv_h;
  logic [3:0] conv_t, conv_u;
  logic [7:0] raw_seg;
  logic [2:0] raw_dig;

  // Changes arriving mid-conversion are simply re-examined once the converter is idle.
  assign conv_start = !conv_busy && (Value != last_q);

  bin2bcd8 u_bin2bcd8 (
    .nReset   (nReset),
    .Clk      (Clk),
    .Start    (conv_start),
    .Value    (Value),
    .Busy     (conv_busy),
    .Load     (conv_load),
    .Hundreds (conv_h),
    .Tens     (conv_t),
    .Units    (conv_u)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      last_q <= 8'd0;
      disp_q <= 10'd0;
      slot_q <= 10'd0;
      idx_q  <= DIG_UNITS;
      seg_q  <= {8{SegActiveLow}};
      dig_q  <= {3{DigActiveLow}};
    end else begin
      last_q <= last_d;
      disp_q <= disp_d;
      slot_q <= slot_d;
      idx_q  <= idx_d;
      seg_q  <= seg_d;
      dig_q  <= dig_d;
    end
  end

  always_comb begin
    last_d = conv_start ? Value : last_q;
    disp_d = conv_load ? {conv_h, conv_t, conv_u} : disp_q;
    slot_d = slot_q + 10'd1;
    idx_d  = idx_q;
    if (slot_q == 10'(ScanDiv - 1)) begin
      slot_d = 10'd0;
      idx_d  = (idx_q == DIG_HUNDREDS) ? DIG_UNITS : idx_q + 2'd1;
    end
  end

  always_comb begin
    raw_seg = 8'h00;
    raw_dig = 3'b000;
    if (slot_q >= 10'(DeadTime)) begin
      case (idx_q)
        DIG_UNITS: begin
          raw_dig = 3'b001;
          raw_seg = {1'b0, seg_decode(disp_q[3:0])};
        end
        DIG_TENS: begin
          raw_dig = 3'b010;
          if (disp_q[9:4] != 6'd0) raw_seg = {1'b0, seg_decode(disp_q[7:4])};
        end
        DIG_HUNDREDS: begin
          raw_dig = 3'b100;
          if (disp_q[9:8] != 2'd0) raw_seg = {1'b0, seg_decode({2'b00, disp_q[9:8]})};
        end
        default: begin
          raw_dig = 3'b000;
          raw_seg = 8'h00;
        end
      endcase
    end
    seg_d = raw_seg ^ {8{SegActiveLow}};
    dig_d = raw_dig ^ {3{DigActiveLow}};
  end

  assign Segments = seg_q;
  assign Digit    = dig_q;
  assign Busy     = conv_busy;

endmodule

// File: tb/tb_pot_display.sv
// Directed bench for pot_display: a default build and an inverted-polarity build
// driven by the same stimulus, checked against hand-computed segment patterns.
module tb_pot_display;

  logic       Clk;
  logic       nReset;
  logic [7:0] Value;
  logic [7:0] seg_a, seg_b;
  logic [2:0] dig_a, dig_b;
  logic       busy_a, busy_b;

  int checks = 0;
  int errors = 0;

  pot_display dut_a (
    .nReset(nReset), .Clk(Clk), .Value(Value),
    .Segments(seg_a), .Digit(dig_a), .Busy(busy_a)
  );

  pot_display #(.SegActiveLow(1'b1), .DigActiveLow(1'b1)) dut_b (
    .nReset(nReset), .Clk(Clk), .Value(Value),
    .Segments(seg_b), .Digit(dig_b), .Busy(busy_b)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Waits for the default build to enable the requested digit and returns both builds' outputs.
  task automatic capture(input logic [2:0] dig, output logic [7:0] sa, output logic [7:0] sb,
                         output logic [2:0] db, output bit ok);
    ok = 1'b0; sa = 8'h00; sb = 8'h00; db = 3'b000;
    for (int i = 0; i < 1500; i++) begin
      @(negedge Clk);
      if (dig_a === dig) begin
        sa = seg_a; sb = seg_b; db = dig_b; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_busy(input logic level, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (busy_a === level) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_display(input string name, input logic [7:0] eh, input logic [7:0] et,
                              input logic [7:0] eu);
    logic [7:0] exp_seg [3];
    logic [2:0] exp_dig [3];
    logic [7:0] sa, sb;
    logic [2:0] db;
    bit ok;
    exp_seg[0] = eu; exp_seg[1] = et; exp_seg[2] = eh;
    exp_dig[0] = 3'b001; exp_dig[1] = 3'b010; exp_dig[2] = 3'b100;
    for (int d = 0; d < 3; d++) begin
      capture(exp_dig[d], sa, sb, db, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL %s digit%0d timeout: got no enable, want %b", name, d, exp_dig[d]);
      end
      checks++;
      if (sa !== exp_seg[d]) begin
        errors++; $display("FAIL %s seg digit%0d: got %h want %h", name, d, sa, exp_seg[d]);
      end
      checks++;
      if (sb !== ~exp_seg[d]) begin
        errors++; $display("FAIL %s inv seg digit%0d: got %h want %h", name, d, sb, ~exp_seg[d]);
      end
      checks++;
      if (db !== ~exp_dig[d]) begin
        errors++; $display("FAIL %s inv dig digit%0d: got %b want %b", name, d, db, ~exp_dig[d]);
      end
      $display("%s digit%0d seg=%h inv_seg=%h inv_dig=%b", name, d, sa, sb, db);
    end
  endtask

  task automatic test_reset();
    nReset = 1'b0; Value = 8'd0;
    repeat (3) @(negedge Clk);
    checks++;
    if ({busy_a, seg_a, dig_a} !== 12'h000) begin
      errors++; $display("FAIL reset_a: got busy=%b seg=%h dig=%b want 0/00/000", busy_a, seg_a, dig_a);
    end
    checks++;
    if ({busy_b, seg_b, dig_b} !== {1'b0, 8'hFF, 3'b111}) begin
      errors++; $display("FAIL reset_b: got busy=%b seg=%h dig=%b want 0/ff/111", busy_b, seg_b, dig_b);
    end
    nReset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      checks++;
      if ({seg_a, dig_a, seg_b, dig_b} !== {8'h00, 3'b000, 8'hFF, 3'b111}) begin
        errors++; $display("FAIL dead_after_reset%0d: got %h/%b %h/%b want 00/000 ff/111", i, seg_a, dig_a, seg_b, dig_b);
      end
    end
    @(negedge Clk);
    checks++;
    if ({seg_a, dig_a} !== {8'h3F, 3'b001}) begin
      errors++; $display("FAIL first_units: got %h/%b want 3f/001", seg_a, dig_a);
    end
    $display("reset first_units seg=%h dig=%b", seg_a, dig_a);
    test_display("reset_000", 8'h00, 8'h00, 8'h3F);
  endtask

  task automatic test_255();
    int cnt_a, cnt_b;
    bit ok;
    Value = 8'd255;
    wait_busy(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy255_rise: got busy=%b want 1", busy_a); end
    cnt_a = 1; cnt_b = (busy_b === 1'b1) ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      if (busy_b === 1'b1) cnt_b++;
      if (busy_a === 1'b1) cnt_a++; else break;
    end
    checks++;
    if (cnt_a != 9) begin errors++; $display("FAIL busy255_len: got %0d want 9", cnt_a); end
    checks++;
    if (cnt_b != 9) begin errors++; $display("FAIL busy255_len_inv: got %0d want 9", cnt_b); end
    $display("value255 busy_clocks=%0d", cnt_a);
    repeat (2) @(negedge Clk);
    test_display("value255", 8'h5B, 8'h6D, 8'h6D);
  endtask

  task automatic test_change_during_shift();
    logic [7:0] exp;
    bit ok;
    Value = 8'd7;
    wait_busy(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy7_rise: got busy=%b want 1", busy_a); end
    repeat (2) @(negedge Clk);
    Value = 8'd200;
    wait_busy(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy7_fall: got busy=%b want 0", busy_a); end
    @(negedge Clk);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL restart200: got busy=%b want 1", busy_a); end
    exp = (dig_a === 3'b001) ? 8'h07 : 8'h00;
    checks++;
    if (seg_a !== exp) begin errors++; $display("FAIL show007: got %h (dig %b) want %h", seg_a, dig_a, exp); end
    $display("value7 shown seg=%h dig=%b busy=%b", seg_a, dig_a, busy_a);
    wait_busy(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy200_fall: got busy=%b want 0", busy_a); end
    repeat (2) @(negedge Clk);
    test_display("value200", 8'h5B, 8'h3F, 8'h3F);
  endtask

  task automatic test_scan_timing();
    int on_cnt, off_cnt, frame;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      if (dig_a === 3'b000) begin ok = 1'b1; break; end
    end
    if (ok) begin
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        @(negedge Clk);
        if (dig_a === 3'b001) begin ok = 1'b1; break; end
      end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL scan_sync: got dig=%b want 001", dig_a); end
    frame = 0; on_cnt = 0; off_cnt = 0;
    while (dig_a === 3'b001 && on_cnt < 2000) begin on_cnt++; @(negedge Clk); frame++; end
    while (dig_a === 3'b000 && off_cnt < 2000) begin off_cnt++; @(negedge Clk); frame++; end
    checks++;
    if (on_cnt != 388) begin errors++; $display("FAIL scan_on: got %0d want 388", on_cnt); end
    checks++;
    if (off_cnt != 2) begin errors++; $display("FAIL scan_dead: got %0d want 2", off_cnt); end
    checks++;
    if (dig_a !== 3'b010 || dig_b !== 3'b101) begin
      errors++; $display("FAIL scan_next: got %b/%b want 010/101", dig_a, dig_b);
    end
    while (dig_a !== 3'b001 && frame < 5000) begin @(negedge Clk); frame++; end
    checks++;
    if (frame != 1170) begin errors++; $display("FAIL scan_frame: got %0d want 1170", frame); end
    $display("scan on=%0d dead=%0d frame=%0d", on_cnt, off_cnt, frame);
  endtask

  task automatic test_reset_mid();
    bit ok;
    Value = 8'd128;
    wait_busy(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy128_rise: got busy=%b want 1", busy_a); end
    repeat (4) @(negedge Clk);
    #2 nReset = 1'b0;
    #1;
    checks++;
    if ({busy_a, seg_a, dig_a} !== 12'h000) begin
      errors++; $display("FAIL midreset_a: got busy=%b seg=%h dig=%b want 0/00/000", busy_a, seg_a, dig_a);
    end
    checks++;
    if ({busy_b, seg_b, dig_b} !== {1'b0, 8'hFF, 3'b111}) begin
      errors++; $display("FAIL midreset_b: got busy=%b seg=%h dig=%b want 0/ff/111", busy_b, seg_b, dig_b);
    end
    $display("midreset busy=%b seg=%h dig=%b", busy_a, seg_a, dig_a);
    @(negedge Clk);
    nReset = 1'b1;
    wait_busy(1'b1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy128_restart: got busy=%b want 1", busy_a); end
    wait_busy(1'b0, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL busy128_fall: got busy=%b want 0", busy_a); end
    repeat (2) @(negedge Clk);
    test_display("value128", 8'h06, 8'h5B, 8'h7F);
  endtask

  initial begin
    nReset = 1'b0;
    Value  = 8'd0;
    test_reset();
    test_255();
    test_change_during_shift();
    test_scan_timing();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
